// File: rtl/apb_arb_pkg.sv
// Shared state encoding, default widths and round-robin pointer helper for the
// APB request arbiter.
package apb_arb_pkg;

  localparam int unsigned DEF_NUM_REQ        = 2;
  localparam int unsigned DEF_ADDR_W         = 32;
  localparam int unsigned DEF_DATA_W         = 32;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 16;

  typedef logic [1:0] state_t;

  localparam state_t IDLE   = 2'd0;
  localparam state_t SETUP  = 2'd1;
  localparam state_t ACCESS = 2'd2;

  // Requester index following idx, wrapping modulo n.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/apb_rr_arbiter.sv
// Combinational round-robin grant: first asserted valid at or after ptr, wrapping.
// The pointer register is owned by the instantiating block.
module apb_rr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [PTR_W-1:0]   ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant
);

  logic found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    if (en) begin
      // Upper segment [ptr, NUM_REQ) has priority over the wrapped segment.
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && valid[i] && (i >= int'(ptr))) begin
          grant[i] = 1'b1;
          found    = 1'b1;
        end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && valid[i]) begin
          grant[i] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/apb_req_arbiter.sv
// Round-robin shared APB master: arbitrates NUM_REQ requesters onto one APB port.
// Optional ACCESS-phase timeout enabled by defining APB_TIMEOUT_EN.
module apb_req_arbiter
  import apb_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ        = DEF_NUM_REQ,
  parameter int unsigned ADDR_W         = DEF_ADDR_W,
  parameter int unsigned DATA_W         = DEF_DATA_W,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                      PCLK,
  input  logic                      PRESET,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic                      PSEL,
  output logic                      PENABLE,
  output logic                      PWRITE,
  output logic [ADDR_W-1:0]         PADDR,
  output logic [DATA_W-1:0]         PWDATA,
  input  logic [DATA_W-1:0]         PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t               state_q, state_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [PTR_W-1:0]     id_q;
  logic                 pwrite_q;
  logic [ADDR_W-1:0]    paddr_q;
  logic [DATA_W-1:0]    pwdata_q;
  logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]    rsp_rdata_q;
  logic                 rsp_err_q;

  logic                 arb_en;
  logic [NUM_REQ-1:0]   grant;
  logic                 accept;
  logic [PTR_W-1:0]     win_idx;
  logic                 sel_write;
  logic [ADDR_W-1:0]    sel_addr;
  logic [DATA_W-1:0]    sel_wdata;
  logic                 done;
  logic                 timeout;
  logic                 fin;

  assign done   = (state_q == ACCESS) && PREADY;
  assign fin    = done || timeout;
  // No handshake while reset is held, so nothing is accepted and then dropped.
  assign arb_en = !PRESET && ((state_q == IDLE) || done);
  assign accept = |grant;

  apb_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_arbiter (
    .valid (req_valid),
    .ptr   (ptr_q),
    .en    (arb_en),
    .grant (grant)
  );

  always_comb begin
    win_idx   = '0;
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        win_idx   = PTR_W'(i);
        sel_write = req_write[i];
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  assign ptr_d = PTR_W'(rr_next(32'(win_idx), NUM_REQ));

`ifdef APB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge PCLK) begin
    if (PRESET || (state_q == SETUP)) begin
      cnt_q <= '0;
    end else if ((state_q == ACCESS) && !PREADY) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Fires on the TIMEOUT_CYCLES-th consecutive wait cycle.
  assign timeout = (state_q == ACCESS) && !PREADY &&
                   (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout_cfg;

  assign timeout            = 1'b0;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = accept ? SETUP : IDLE;
      SETUP:   state_d = ACCESS;
      ACCESS: begin
        if (PREADY) begin
          state_d = accept ? SETUP : IDLE;
        end else if (timeout) begin
          state_d = IDLE;
        end else begin
          state_d = ACCESS;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rsp_valid_d = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_valid_d[i] = fin && (id_q == PTR_W'(i));
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      id_q        <= '0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= rsp_valid_d;
      if (accept) begin
        ptr_q    <= ptr_d;
        id_q     <= win_idx;
        pwrite_q <= sel_write;
        paddr_q  <= sel_addr;
        pwdata_q <= sel_write ? sel_wdata : '0;
      end
      if (fin) begin
        rsp_rdata_q <= (timeout || pwrite_q) ? '0 : PRDATA;
        rsp_err_q   <= timeout || PSLVERR;
      end
    end
  end

  assign req_ready = grant;
  assign PSEL      = (state_q != IDLE);
  assign PENABLE   = (state_q == ACCESS);
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed self-checking bench for apb_req_arbiter (two requesters, 32-bit APB).
// The timeout step is included when APB_TIMEOUT_EN is defined.
module tb_apb_req_arbiter;

  localparam int unsigned NUM_REQ = 2;
  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 32;

  logic                      PCLK = 1'b0;
  logic                      PRESET;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        req_write;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_rdata;
  logic                      rsp_err;
  logic                      PSEL;
  logic                      PENABLE;
  logic                      PWRITE;
  logic [ADDR_W-1:0]         PADDR;
  logic [DATA_W-1:0]         PWDATA;
  logic [DATA_W-1:0]         PRDATA;
  logic                      PREADY;
  logic                      PSLVERR;

  int n_assert = 0;
  int n_fail   = 0;

  apb_req_arbiter #(
    .NUM_REQ        (NUM_REQ),
    .ADDR_W         (ADDR_W),
    .DATA_W         (DATA_W),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .PCLK      (PCLK),
    .PRESET    (PRESET),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PWRITE    (PWRITE),
    .PADDR     (PADDR),
    .PWDATA    (PWDATA),
    .PRDATA    (PRDATA),
    .PREADY    (PREADY),
    .PSLVERR   (PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] e;

    PRESET    = 1'b1;
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    PRDATA    = '0;
    PREADY    = 1'b0;
    PSLVERR   = 1'b0;
    step();
    step();
    chk("rst_psel",      64'(PSEL),      64'h0);
    chk("rst_penable",   64'(PENABLE),   64'h0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
    chk("rst_paddr",     64'(PADDR),     64'h0);
    chk("rst_pwdata",    64'(PWDATA),    64'h0);
    chk("rst_pwrite",    64'(PWRITE),    64'h0);
    chk("rst_rsp_rdata", 64'(rsp_rdata), 64'h0);
    chk("rst_rsp_err",   64'(rsp_err),   64'h0);
    PRESET = 1'b0;
    step();

    // Single write from requester 0, zero wait states.
    req_valid       = 2'b01;
    req_write       = 2'b01;
    req_addr[31:0]  = 32'h10;
    req_wdata[31:0] = 32'hA5;
    PREADY          = 1'b1;
    #1;
    chk("t1_ready", 64'(req_ready), 64'h1);
    step();
    req_valid = '0;
    #1;
    chk("t1_setup_psel",    64'(PSEL),      64'h1);
    chk("t1_setup_penable", 64'(PENABLE),   64'h0);
    chk("t1_paddr",         64'(PADDR),     64'h10);
    chk("t1_pwdata",        64'(PWDATA),    64'hA5);
    chk("t1_pwrite",        64'(PWRITE),    64'h1);
    step();
    chk("t1_access_penable", 64'(PENABLE),   64'h1);
    chk("t1_access_rsp",     64'(rsp_valid), 64'h0);
    step();
    chk("t1_rsp_valid", 64'(rsp_valid), 64'h1);
    chk("t1_rsp_err",   64'(rsp_err),   64'h0);
    chk("t1_idle_psel", 64'(PSEL),      64'h0);
    step();
    chk("t1_rsp_pulse_end", 64'(rsp_valid), 64'h0);

    // Read from requester 1 with three wait states.
    req_valid        = 2'b10;
    req_write        = 2'b00;
    req_addr[63:32]  = 32'h20;
    PREADY           = 1'b0;
    #1;
    chk("t2_ready", 64'(req_ready), 64'h2);
    step();
    req_valid = '0;
    #1;
    chk("t2_paddr",   64'(PADDR),   64'h20);
    chk("t2_pwrite",  64'(PWRITE),  64'h0);
    chk("t2_pwdata",  64'(PWDATA),  64'h0);
    chk("t2_penable", 64'(PENABLE), 64'h0);
    for (int k = 0; k < 4; k++) begin
      step();
      if (k == 3) begin
        PREADY = 1'b1;
        PRDATA = 32'h1234;
      end
      chk("t2_wait_penable", 64'(PENABLE),   64'h1);
      chk("t2_wait_no_rsp",  64'(rsp_valid), 64'h0);
    end
    step();
    chk("t2_rsp_valid", 64'(rsp_valid), 64'h2);
    chk("t2_rsp_rdata", 64'(rsp_rdata), 64'h1234);
    chk("t2_rsp_err",   64'(rsp_err),   64'h0);
    chk("t2_penable",   64'(PENABLE),   64'h0);

    // Both requesters held valid: eight back-to-back alternating writes.
    req_valid         = 2'b11;
    req_write         = 2'b11;
    req_addr[31:0]    = 32'h100;
    req_addr[63:32]   = 32'h200;
    req_wdata[31:0]   = 32'h11;
    req_wdata[63:32]  = 32'h22;
    #1;
    chk("t3_first_ready", 64'(req_ready), 64'h1);
    for (int t = 0; t < 8; t++) begin
      step();
      if (t == 7) req_valid = '0;
      #1;
      chk("t3_setup_psel",    64'(PSEL),    64'h1);
      chk("t3_setup_penable", 64'(PENABLE), 64'h0);
      e = (t % 2 == 0) ? 64'h100 : 64'h200;
      chk("t3_paddr", 64'(PADDR), e);
      e = (t % 2 == 0) ? 64'h11 : 64'h22;
      chk("t3_pwdata", 64'(PWDATA), e);
      e = (t == 0) ? 64'h0 : 64'(1 << ((t - 1) % 2));
      chk("t3_rsp_id", 64'(rsp_valid), e);
      step();
      chk("t3_access_penable", 64'(PENABLE), 64'h1);
      e = (t < 7) ? 64'(1 << ((t + 1) % 2)) : 64'h0;
      chk("t3_rr_ready", 64'(req_ready), e);
    end
    step();
    chk("t3_last_rsp",   64'(rsp_valid), 64'h2);
    chk("t3_last_rdata", 64'(rsp_rdata), 64'h0);
    chk("t3_idle_psel",  64'(PSEL),      64'h0);

    // Slave error on one transfer, clean read right after.
    req_valid = 2'b01;
    req_write = 2'b01;
    #1;
    chk("t4_ready0", 64'(req_ready), 64'h1);
    step();
    req_valid = '0;
    PSLVERR   = 1'b1;
    step();
    step();
    chk("t4_err_rsp", 64'(rsp_valid), 64'h1);
    chk("t4_err_set", 64'(rsp_err),   64'h1);
    PSLVERR   = 1'b0;
    req_valid = 2'b10;
    req_write = 2'b00;
    PRDATA    = 32'hBEEF;
    #1;
    chk("t4_ready1", 64'(req_ready), 64'h2);
    step();
    req_valid = '0;
    step();
    step();
    chk("t4_ok_rsp",   64'(rsp_valid), 64'h2);
    chk("t4_ok_err",   64'(rsp_err),   64'h0);
    chk("t4_ok_rdata", 64'(rsp_rdata), 64'hBEEF);

    // Reset while ACCESS is stalled; pointer was advanced to 1 beforehand.
    req_valid = 2'b01;
    req_write = 2'b01;
    PREADY    = 1'b0;
    step();
    req_valid = '0;
    step();
    step();
    chk("t5_stalled_penable", 64'(PENABLE), 64'h1);
    PRESET = 1'b1;
    step();
    chk("t5_rst_psel",      64'(PSEL),      64'h0);
    chk("t5_rst_penable",   64'(PENABLE),   64'h0);
    chk("t5_rst_ready",     64'(req_ready), 64'h0);
    chk("t5_rst_rsp_valid", 64'(rsp_valid), 64'h0);
    PRESET = 1'b0;
    PREADY = 1'b1;
    step();
    chk("t5_no_rsp_a", 64'(rsp_valid), 64'h0);
    chk("t5_idle_psel", 64'(PSEL),     64'h0);
    step();
    chk("t5_no_rsp_b", 64'(rsp_valid), 64'h0);
    req_valid = 2'b11;
    #1;
    chk("t5_ptr_reset_ready", 64'(req_ready), 64'h1);
    step();
    req_valid = '0;
    step();
    step();
    chk("t5_post_rst_rsp", 64'(rsp_valid), 64'h1);

`ifdef APB_TIMEOUT_EN
    // PREADY stuck low: transfer abandoned after 16 wait cycles.
    req_valid = 2'b10;
    req_write = 2'b00;
    PREADY    = 1'b0;
    PRDATA    = 32'hDEAD;
    #1;
    chk("t6_ready", 64'(req_ready), 64'h2);
    step();
    req_valid = '0;
    for (int k = 0; k < 16; k++) begin
      step();
      chk("t6_wait_penable", 64'(PENABLE),   64'h1);
      chk("t6_wait_no_rsp",  64'(rsp_valid), 64'h0);
    end
    step();
    chk("t6_to_psel",    64'(PSEL),      64'h0);
    chk("t6_to_penable", 64'(PENABLE),   64'h0);
    chk("t6_to_rsp",     64'(rsp_valid), 64'h2);
    chk("t6_to_err",     64'(rsp_err),   64'h1);
    chk("t6_to_rdata",   64'(rsp_rdata), 64'h0);
    PREADY = 1'b1;
    step();
    chk("t6_late_ready_rsp",  64'(rsp_valid), 64'h0);
    chk("t6_late_ready_psel", 64'(PSEL),      64'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_req_arbiter.md
Name: apb_req_arbiter

Overview:
- Multi-requester APB master controller that shares one APB slave port between NUM_REQ requesters.
- Arbitrates round-robin and sequences the APB SETUP/ACCESS phases, waiting on PREADY and capturing PRDATA/PSLVERR.
- Returns a per-requester response pulse on completion.
- Sits between internal initiators (DMA, config sequencers, CPU shim) and the APB slave fabric.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ADDR_W, 32, PADDR width.
- DATA_W, 32, PWDATA/PRDATA width.
- TIMEOUT_CYCLES, 16, maximum ACCESS-phase wait (used only with APB_TIMEOUT_EN).

Ports:
- PCLK  in  1  clock; all logic on rising edge.
- PRESET  in  1  reset, synchronous, active-high.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  one-hot accept; transfer accepted when valid&ready.
- req_write  in  NUM_REQ  1 = write, 0 = read.
- req_addr  in  NUM_REQ*ADDR_W  flattened addresses; slice i = requester i.
- req_wdata  in  NUM_REQ*DATA_W  flattened write data.
- rsp_valid  out  NUM_REQ  one-hot, one-cycle completion pulse.
- rsp_rdata  out  DATA_W  read data, valid with rsp_valid.
- rsp_err  out  1  PSLVERR (or timeout) status, valid with rsp_valid.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PADDR  out  ADDR_W  APB address.
- PWDATA  out  DATA_W  APB write data.
- PRDATA  in  DATA_W  APB read data.
- PREADY  in  1  APB ready.
- PSLVERR  in  1  APB slave error.

Behaviour:
- Reset (PRESET=1 at an edge):
  - state=IDLE and rr pointer=0.
  - All outputs 0.
  - Mid-transfer reset abandons the transfer: PSEL/PENABLE are 0 after that edge and no rsp_valid is issued.
- FSM IDLE, SETUP, ACCESS.
- Arbitration window: state==IDLE, or the ACCESS cycle with PREADY=1.
  - Winner = first asserted req_valid at or after the rr pointer, wrapping modulo NUM_REQ.
  - req_ready[winner]=1 combinationally in that cycle only; all other req_ready are 0.
  - The rr pointer becomes winner+1 (wrapping) on acceptance.
  - The pointer is unchanged when there is no request.
- Accept edge: latch winner id, write, addr and wdata; state goes to SETUP.
  - Requesters hold their fields stable until accepted.
- SETUP: PSEL=1, PENABLE=0, PADDR/PWRITE driven from latched values, PWDATA=wdata on writes and 0 on reads. Next state is ACCESS unconditionally.
- ACCESS:
  - PSEL=1, PENABLE=1, all address/data/control held stable.
  - If PREADY=0, stay in ACCESS.
  - If PREADY=1, capture PRDATA (reads; 0 for writes) and PSLVERR into rsp_rdata/rsp_err, and pulse rsp_valid[id] on the next cycle.
- Back-to-back transfers:
  - If a request is accepted in the completing ACCESS cycle, the next state is SETUP directly. PSEL stays 1 and PENABLE drops to 0.
  - Otherwise the next state is IDLE with PSEL=0 and PENABLE=0.
- Latency: accept at cycle N gives SETUP at N+1, ACCESS at N+2, and rsp_valid at N+3 when PREADY=1 at N+2. Each PREADY=0 cycle adds 1.
- In IDLE, PADDR/PWRITE/PWDATA hold their last values; rsp_rdata/rsp_err hold until the next response.
- A requester whose own response is pulsing may be re-granted in the same cycle.
- A single active requester gets consecutive grants.

Optional Feature:
- APB_TIMEOUT_EN defined:
  - A counter clears on SETUP and increments each ACCESS cycle with PREADY=0.
  - When it reaches TIMEOUT_CYCLES, the transfer ends: state goes to IDLE, PSEL/PENABLE go to 0, rsp_valid[id] pulses with rsp_err=1 and rsp_rdata=0.
  - A late PREADY is then ignored.
- Undefined: no counter; ACCESS waits indefinitely for PREADY.

Decomposition:
- Package apb_arb_pkg holds:
  - state enum (IDLE, SETUP, ACCESS);
  - default width constants;
  - a function for the round-robin next-pointer wrap.
- Sub-module apb_rr_arbiter (NUM_REQ): inputs are the valid vector, rr pointer and an enable; output is the one-hot grant. It is purely combinational; the pointer register lives in the top.

Test Plan:
- Single write: req 0 writes addr 0x10 data 0xA5 with PREADY=1 -> PSEL up at N+1, PENABLE at N+2, PADDR=0x10, PWDATA=0xA5, rsp_valid=01 at N+3, rsp_err=0.
- Read with wait states: req 1 reads 0x20, slave holds PREADY=0 for 3 cycles then returns PRDATA=0x1234 -> PENABLE high 4 cycles, rsp_rdata=0x1234, rsp_valid=10 at N+6.
- Round-robin: both requesters hold valid continuously (4 transfers each) -> grants alternate 0,1,0,1…; back-to-back SETUPs with no PSEL=0 gap; every response id matches.
- Slave error: PSLVERR=1 with PREADY -> rsp_err=1 for that response only; next transfer reports rsp_err=0.
- Reset mid-ACCESS: PRESET=1 while PREADY=0 -> PSEL/PENABLE/req_ready/rsp_valid all 0 after the edge, no response issued, first grant after reset goes to requester 0.
- APB_TIMEOUT_EN, PREADY stuck 0 -> after 16 ACCESS cycles, rsp_err=1, rsp_rdata=0, state returns to IDLE.
